time_disp_driver: RTL and testbench

- Display back end for the 24-hour clock: consumes the binary hour/minute/second fields and drives a 6-digit multiplexed common-anode 7-segment display as HH.MM.SS.
- Captures a time sample on a strobe and converts each field to BCD with a sequential shift-add-3 converter.
- Scans the digits at a divided kh_clk rate.
- Sits directly downstream of the 24-hour counter; the milliseconds field is not displayed.

---
 rtl/time_disp_pkg.sv | 44 ++++
 rtl/time_disp_driver_bcd.sv | 52 +++++
 rtl/time_disp_driver.sv | 219 +++++++++++++++++++++
 tb/tb_time_disp_driver.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/time_disp_pkg.sv
// Shared definitions for the HH.MM.SS display back end: segment patterns,
// digit positions, FSM states, field limits and the shift-add-3 helper.
package time_disp_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [2:0] DIG_SEC_ONES = 3'd0;
   localparam logic [2:0] DIG_SEC_TENS = 3'd1;
   localparam logic [2:0] DIG_MIN_ONES = 3'd2;
   localparam logic [2:0] DIG_MIN_TENS = 3'd3;
   localparam logic [2:0] DIG_HR_ONES  = 3'd4;
   localparam logic [2:0] DIG_HR_TENS  = 3'd5;

   localparam logic [4:0] HR_MAX = 5'd23;
   localparam logic [5:0] MS_MAX = 6'd59;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV   = 2'd1,
      COMMIT = 2'd2
   } state_e;

   typedef struct packed {
      logic [4:0] h;
      logic [5:0] m;
      logic [5:0] s;
   } sample_t;

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? (d + 4'd3) : d;
   endfunction

endpackage

// File: rtl/time_disp_driver_bcd.sv
// Sequential 6-bit binary to two-digit BCD converter (shift-add-3).
// start performs the first step; done holds after the sixth step.
module bin6_to_bcd_seq
   import time_disp_pkg::*;
(
   input  logic       kh_clk,
   input  logic       reset,
   input  logic       start,
   input  logic [5:0] bin,
   output logic       done,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   logic [7:0] bcd_q, bcd_d;
   logic [2:0] cnt_q, cnt_d;
   logic [2:0] bit_sel_s;
   logic [3:0] t_adj_s, o_adj_s;

   always_comb begin
      bcd_d     = bcd_q;
      cnt_d     = cnt_q;
      bit_sel_s = 3'd5 - cnt_q;
      t_adj_s   = add3(bcd_q[7:4]);
      o_adj_s   = add3(bcd_q[3:0]);
      if (start) begin
         bcd_d = {7'd0, bin[5]};
         cnt_d = 3'd1;
      end else if ((cnt_q != 3'd0) && (cnt_q != 3'd6)) begin
         bcd_d = {t_adj_s[2:0], o_adj_s, bin[bit_sel_s]};
         cnt_d = cnt_q + 3'd1;
      end else begin
         bcd_d = bcd_q;
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge kh_clk or posedge reset) begin
      if (reset) begin
         bcd_q <= 8'd0;
         cnt_q <= 3'd0;
      end else begin
         bcd_q <= bcd_d;
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == 3'd6);
   assign tens = bcd_q[7:4];
   assign ones = bcd_q[3:0];

endmodule

// File: rtl/time_disp_driver.sv
// Captures hh:mm:ss samples, converts them to BCD through one shared serial
// converter, and scans six active-low 7-segment digits.
module time_disp_driver
   import time_disp_pkg::*;
#(
   parameter int REFRESH_DIV = 2,
   parameter bit LEAD_BLANK  = 1'b1
)
(
   input  logic       kh_clk,
   input  logic       reset,
   input  logic       time_valid,
   input  logic [4:0] hr,
   input  logic [5:0] min,
   input  logic [5:0] sec,
   output logic       busy,
   output logic       range_err,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   state_e          state_q, state_d;
   sample_t         smp_q, smp_d, pend_q, pend_d, smp_in_s;
   logic            pend_v_q, pend_v_d;
   logic [4:0]      cyc_q, cyc_d;
   logic [7:0]      hr_bcd_q, hr_bcd_d, min_bcd_q, min_bcd_d;
   logic [5:0][3:0] dig_q, dig_d;
   logic            rerr_q, rerr_d, busy_q, busy_d;
   logic            conv_start_s, conv_done_s;
   logic [5:0]      conv_bin_s;
   logic [3:0]      conv_tens_s, conv_ones_s;

   logic [RC_W-1:0] rc_q, rc_d;
   logic [2:0]      idx_q, idx_d;
   logic [5:0]      an_q, an_d;
   logic [6:0]      seg_q, seg_d, seg_raw_s;
   logic            dp_q, dp_d, wrap_s;
   logic [3:0]      dig_s;

   assign smp_in_s = {hr, min, sec};

   // One converter serves hr, min, sec in turn, six cycles each.
   always_comb begin
      if (cyc_q < 5'd6)       conv_bin_s = {1'b0, smp_q.h};
      else if (cyc_q < 5'd12) conv_bin_s = smp_q.m;
      else                    conv_bin_s = smp_q.s;
   end

   bin6_to_bcd_seq u_conv (
      .kh_clk (kh_clk),
      .reset  (reset),
      .start  (conv_start_s),
      .bin    (conv_bin_s),
      .done   (conv_done_s),
      .tens   (conv_tens_s),
      .ones   (conv_ones_s)
   );

   // Capture / convert / commit sequencing with a single newest-wins pending slot.
   always_comb begin
      state_d      = state_q;
      smp_d        = smp_q;
      pend_d       = pend_q;
      pend_v_d     = pend_v_q;
      cyc_d        = cyc_q;
      hr_bcd_d     = hr_bcd_q;
      min_bcd_d    = min_bcd_q;
      dig_d        = dig_q;
      rerr_d       = rerr_q;
      conv_start_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (time_valid) begin
               smp_d   = smp_in_s;
               cyc_d   = 5'd0;
               state_d = CONV;
            end else begin
               state_d = IDLE;
            end
         end
         CONV: begin
            conv_start_s = (cyc_q == 5'd0) || (cyc_q == 5'd6) || (cyc_q == 5'd12);
            if (conv_done_s && (cyc_q == 5'd6)) hr_bcd_d = {conv_tens_s, conv_ones_s};
            else                                hr_bcd_d = hr_bcd_q;
            if (conv_done_s && (cyc_q == 5'd12)) min_bcd_d = {conv_tens_s, conv_ones_s};
            else                                 min_bcd_d = min_bcd_q;
            if (time_valid) begin
               pend_d   = smp_in_s;
               pend_v_d = 1'b1;
            end else begin
               pend_v_d = pend_v_q;
            end
            if (cyc_q == 5'd17) state_d = COMMIT;
            else                cyc_d   = cyc_q + 5'd1;
         end
         COMMIT: begin
            // A strobe landing on the commit cycle is newer than anything pending.
            dig_d    = {hr_bcd_q, min_bcd_q, conv_tens_s, conv_ones_s};
            rerr_d   = (smp_q.h > HR_MAX) || (smp_q.m > MS_MAX) || (smp_q.s > MS_MAX);
            pend_v_d = 1'b0;
            cyc_d    = 5'd0;
            if (time_valid) begin
               smp_d   = smp_in_s;
               state_d = CONV;
            end else if (pend_v_q) begin
               smp_d   = pend_q;
               state_d = CONV;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // FSM and datapath registers.
   always_ff @(posedge kh_clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         smp_q     <= '0;
         pend_q    <= '0;
         pend_v_q  <= 1'b0;
         cyc_q     <= 5'd0;
         hr_bcd_q  <= 8'd0;
         min_bcd_q <= 8'd0;
         dig_q     <= '0;
         rerr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         smp_q     <= smp_d;
         pend_q    <= pend_d;
         pend_v_q  <= pend_v_d;
         cyc_q     <= cyc_d;
         hr_bcd_q  <= hr_bcd_d;
         min_bcd_q <= min_bcd_d;
         dig_q     <= dig_d;
         rerr_q    <= rerr_d;
         busy_q    <= busy_d;
      end
   end

   // Scan: next digit index, its decoded pattern and separator, loaded on wrap.
   always_comb begin
      wrap_s = (rc_q == RC_W'(REFRESH_DIV - 1));
      if (wrap_s) begin
         rc_d  = '0;
         idx_d = (idx_q == DIG_HR_TENS) ? DIG_SEC_ONES : (idx_q + 3'd1);
      end else begin
         rc_d  = rc_q + RC_W'(1);
         idx_d = idx_q;
      end
      case (idx_d)
         DIG_SEC_ONES: dig_s = dig_q[0];
         DIG_SEC_TENS: dig_s = dig_q[1];
         DIG_MIN_ONES: dig_s = dig_q[2];
         DIG_MIN_TENS: dig_s = dig_q[3];
         DIG_HR_ONES:  dig_s = dig_q[4];
         DIG_HR_TENS:  dig_s = dig_q[5];
         default:      dig_s = 4'd0;
      endcase
      case (dig_s)
         4'd0:    seg_raw_s = SEG_0;
         4'd1:    seg_raw_s = SEG_1;
         4'd2:    seg_raw_s = SEG_2;
         4'd3:    seg_raw_s = SEG_3;
         4'd4:    seg_raw_s = SEG_4;
         4'd5:    seg_raw_s = SEG_5;
         4'd6:    seg_raw_s = SEG_6;
         4'd7:    seg_raw_s = SEG_7;
         4'd8:    seg_raw_s = SEG_8;
         4'd9:    seg_raw_s = SEG_9;
         default: seg_raw_s = SEG_BLANK;
      endcase
      if (rerr_q)
         seg_d = SEG_DASH;
      else if (LEAD_BLANK && (idx_d == DIG_HR_TENS) && (dig_s == 4'd0))
         seg_d = SEG_BLANK;
      else
         seg_d = seg_raw_s;
      if (rerr_q) dp_d = 1'b1;
      else        dp_d = !((idx_d == DIG_MIN_ONES) || (idx_d == DIG_HR_ONES));
      an_d = ~(6'b000001 << idx_d);
   end

   // Scan registers; outputs move only on refresh wrap.
   always_ff @(posedge kh_clk or posedge reset) begin
      if (reset) begin
         rc_q  <= '0;
         idx_q <= DIG_SEC_ONES;
         an_q  <= 6'b111110;
         seg_q <= SEG_0;
         dp_q  <= 1'b1;
      end else begin
         rc_q  <= rc_d;
         idx_q <= idx_d;
         if (wrap_s) begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
         end else begin
            an_q  <= an_q;
            seg_q <= seg_q;
            dp_q  <= dp_q;
         end
      end
   end

   assign busy      = busy_q;
   assign range_err = rerr_q;
   assign an        = an_q;
   assign seg       = seg_q;
   assign dp        = dp_q;

endmodule

// File: tb/tb_time_disp_driver.sv
// Self-checking bench for time_disp_driver: directed scenarios plus random
// strobes, every output compared each cycle against a timing-level model.
module tb_time_disp_driver;

   localparam int DIV = 2;
   localparam logic [6:0] PAT [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                       7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                       7'b0000000, 7'b0010000};

   logic       kh_clk = 1'b0;
   logic       reset = 1'b1;
   logic       time_valid = 1'b0;
   logic [4:0] hr = 5'd0;
   logic [5:0] min = 6'd0;
   logic [5:0] sec = 6'd0;
   logic       busy, range_err, dp;
   logic [5:0] an;
   logic [6:0] seg;

   int checks = 0;
   int failures = 0;

   time_disp_driver #(.REFRESH_DIV(DIV), .LEAD_BLANK(1'b1)) dut (
      .kh_clk     (kh_clk),
      .reset      (reset),
      .time_valid (time_valid),
      .hr         (hr),
      .min        (min),
      .sec        (sec),
      .busy       (busy),
      .range_err  (range_err),
      .an         (an),
      .seg        (seg),
      .dp         (dp)
   );

   always #5 kh_clk = ~kh_clk;

   // Reference model: display contents, commit schedule, scan position.
   int         m_dig [6];
   bit         m_err, m_busy, n_v;
   int         m_commit, ec, c_h, c_m, c_s, n_h, n_m, n_s, rc, idx;
   logic [5:0] e_an;
   logic [6:0] e_seg;
   logic       e_dp;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s @edge %0d: got=%0h expected=%0h", tag, ec, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 6; i++) m_dig[i] = 0;
      m_err = 1'b0; m_busy = 1'b0; n_v = 1'b0;
      rc = 0; idx = 0;
      e_an = 6'b111110; e_seg = 7'b1000000; e_dp = 1'b1;
   endtask

   task automatic start_conv(input int h, input int m, input int s);
      c_h = h; c_m = m; c_s = s;
      m_commit = ec + 19;
      m_busy = 1'b1;
   endtask

   task automatic model_edge(input bit tv, input int h, input int m, input int s);
      if (rc == DIV - 1) begin
         rc = 0;
         idx = (idx + 1) % 6;
         e_an = ~(6'b000001 << idx);
         if (m_err)                         e_seg = 7'b0111111;
         else if (idx == 5 && m_dig[5] == 0) e_seg = 7'b1111111;
         else                               e_seg = PAT[m_dig[idx]];
         e_dp = m_err ? 1'b1 : !(idx == 2 || idx == 4);
      end else begin
         rc = rc + 1;
      end
      if (m_busy && ec == m_commit) begin
         m_dig[0] = c_s % 10; m_dig[1] = c_s / 10;
         m_dig[2] = c_m % 10; m_dig[3] = c_m / 10;
         m_dig[4] = c_h % 10; m_dig[5] = c_h / 10;
         m_err = (c_h > 23) || (c_m > 59) || (c_s > 59);
         if (tv)       start_conv(h, m, s);
         else if (n_v) start_conv(n_h, n_m, n_s);
         else          m_busy = 1'b0;
         n_v = 1'b0;
      end else if (m_busy) begin
         if (tv) begin
            n_v = 1'b1; n_h = h; n_m = m; n_s = s;
         end
      end else if (tv) begin
         start_conv(h, m, s);
      end
   endtask

   task automatic check_outputs();
      check_eq("an",        32'(an),        32'(e_an));
      check_eq("seg",       32'(seg),       32'(e_seg));
      check_eq("dp",        32'(dp),        32'(e_dp));
      check_eq("busy",      32'(busy),      32'(m_busy));
      check_eq("range_err", 32'(range_err), 32'(m_err));
   endtask

   task automatic tick(input bit tv, input int h, input int m, input int s);
      time_valid = tv;
      hr  = h[4:0];
      min = m[5:0];
      sec = s[5:0];
      @(posedge kh_clk);
      ec++;
      if (reset) model_reset();
      else       model_edge(tv, h, m, s);
      @(negedge kh_clk);
      time_valid = 1'b0;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 0);
   endtask

   initial begin
      int h, m, s;
      ec = 0;
      model_reset();
      tick(1'b0, 0, 0, 0);
      tick(1'b0, 0, 0, 0);
      reset = 1'b0;

      // Reset scan: two full rotations.
      idle(24);

      tick(1'b1, 23, 59, 58);
      idle(30);

      tick(1'b1, 12, 34, 56);
      idle(4);
      tick(1'b1, 7, 8, 9);
      idle(4);
      tick(1'b1, 13, 0, 0);
      idle(45);

      tick(1'b1, 24, 0, 0);
      idle(25);
      tick(1'b1, 0, 0, 1);
      idle(25);

      // Asynchronous reset in the middle of a conversion.
      tick(1'b1, 10, 20, 30);
      idle(9);
      reset = 1'b1;
      #1;
      check_eq("arst_an",   32'(an),        32'(6'b111110));
      check_eq("arst_seg",  32'(seg),       32'(7'b1000000));
      check_eq("arst_dp",   32'(dp),        32'(1'b1));
      check_eq("arst_busy", 32'(busy),      32'(1'b0));
      check_eq("arst_rerr", 32'(range_err), 32'(1'b0));
      model_reset();
      tick(1'b0, 0, 0, 0);
      reset = 1'b0;
      idle(30);

      tick(1'b1, 1, 2, 3);
      tick(1'b1, 4, 5, 6);
      idle(45);

      // Random strobes, mostly legal fields with occasional out-of-range ones.
      for (int i = 0; i < 900; i++) begin
         h = ($urandom_range(9) == 0) ? int'($urandom_range(31)) : int'($urandom_range(23));
         m = ($urandom_range(9) == 0) ? int'($urandom_range(63)) : int'($urandom_range(59));
         s = ($urandom_range(9) == 0) ? int'($urandom_range(63)) : int'($urandom_range(59));
         tick($urandom_range(11) == 0, h, m, s);
      end
      idle(45);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
